// File: rtl/apb_gpio_slave.sv
// rtl/apb_gpio_slave.sv - APB GPIO completer: wait states, PSLVERR, byte-lane writes, synchronized inputs
// Define APB_GPIO_IRQ_EN to build IRQ_EN/IRQ_STATUS, rising-edge detection and the irq output.
module apb_gpio_slave #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int STRB_WIDTH    = 4,
  parameter int WAIT_STATES   = 1
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDRESS_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic [STRB_WIDTH-1:0]    PSTRB,
  output logic [DATA_WIDTH-1:0]    PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  input  logic [DATA_WIDTH-1:0]    gpio_in,
  output logic [DATA_WIDTH-1:0]    gpio_out,
  output logic [DATA_WIDTH-1:0]    gpio_oe,
  output logic                     irq
);
  localparam logic [2:0] IDX_DOUT = 3'd0;
  localparam logic [2:0] IDX_DIR  = 3'd1;
  localparam logic [2:0] IDX_DIN  = 3'd2;
`ifdef APB_GPIO_IRQ_EN
  localparam logic [2:0] IDX_IEN  = 3'd3;
  localparam logic [2:0] IDX_IST  = 3'd4;
`endif
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [2:0]            idx_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0] dout_q, dir_q;
  logic [DATA_WIDTH-1:0] sync0_q, sync1_q;
  logic [DATA_WIDTH-1:0] bmask;
  logic [2:0]            r_idx;
  logic                  r_wr, r_err, commit;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  unused_paddr;

  assign unused_paddr = ^PADDR[ADDRESS_WIDTH-1:3];

  // With zero wait states the response is produced on the setup edge, so decode the live bus.
  assign r_idx = (state_q == S_IDLE) ? PADDR[2:0] : idx_q;
  assign r_wr  = (state_q == S_IDLE) ? PWRITE : wr_q;

`ifdef APB_GPIO_IRQ_EN
  logic [DATA_WIDTH-1:0] ien_q, ist_q, prev_q, w1c;
`endif

  always_comb begin
    r_data = '0;
    r_err  = 1'b0;
    case (r_idx)
      IDX_DOUT: r_data = dout_q;
      IDX_DIR:  r_data = dir_q;
      IDX_DIN: begin
        r_data = sync1_q;
        r_err  = r_wr;
      end
`ifdef APB_GPIO_IRQ_EN
      IDX_IEN:  r_data = ien_q;
      IDX_IST:  r_data = ist_q;
`endif
      default:  r_err = 1'b1;
    endcase
    if (r_err || r_wr) r_data = '0;
  end

  always_comb begin
    bmask = '0;
    for (int b = 0; b < STRB_WIDTH; b++) bmask[b*8 +: 8] = {8{strb_q[b]}};
  end

  assign commit = (state_q == S_DONE) && PSEL && PENABLE && wr_q && !PSLVERR;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (PSEL && !PENABLE) begin
            idx_q   <= PADDR[2:0];
            wr_q    <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            cnt_q   <= WS;
            if (WAIT_STATES == 0) begin
              state_q <= S_DONE;
              PREADY  <= 1'b1;
              PRDATA  <= r_data;
              PSLVERR <= r_err;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!PSEL) begin
            state_q <= S_IDLE;
          end else if (cnt_q <= 4'd1) begin
            state_q <= S_DONE;
            PREADY  <= 1'b1;
            PRDATA  <= r_data;
            PSLVERR <= r_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      dout_q  <= '0;
      dir_q   <= '0;
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= gpio_in;
      sync1_q <= sync0_q;
      if (commit && idx_q == IDX_DOUT) dout_q <= (dout_q & ~bmask) | (wdata_q & bmask);
      if (commit && idx_q == IDX_DIR)  dir_q  <= (dir_q & ~bmask) | (wdata_q & bmask);
    end
  end

`ifdef APB_GPIO_IRQ_EN
  assign w1c = (commit && idx_q == IDX_IST) ? (wdata_q & bmask) : '0;

  // A new edge is OR-ed in after the clear so it survives a same-cycle W1C.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ien_q  <= '0;
      ist_q  <= '0;
      prev_q <= '0;
      irq    <= 1'b0;
    end else begin
      prev_q <= sync1_q;
      if (commit && idx_q == IDX_IEN) ien_q <= (ien_q & ~bmask) | (wdata_q & bmask);
      ist_q  <= (ist_q & ~w1c) | (sync1_q & ~prev_q & ien_q);
      irq    <= |(ist_q & ien_q);
    end
  end
`else
  assign irq = 1'b0;
`endif

  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;
endmodule

// File: tb/tb_apb_gpio_slave.sv
// tb/tb_apb_gpio_slave.sv - vector table, hand sequences and randomized model check of apb_gpio_slave
module tb_apb_gpio_slave;
`ifdef APB_GPIO_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       psel;
  logic             PENABLE, PWRITE;
  logic [3:0]       PADDR;
  logic [31:0]      PWDATA, pins;
  logic [3:0]       PSTRB;
  logic [2:0][31:0] rdat, gout, goe;
  logic [2:0]       rdy, serr, girq;

  int total = 0;
  int passed = 0;

  logic [31:0] m_dout, m_dir, m_ien, m_ist, m_pins;

  always #5 clk = ~clk;

  apb_gpio_slave #(.WAIT_STATES(1)) u_ws1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(rdat[0]), .PREADY(rdy[0]),
    .PSLVERR(serr[0]), .gpio_in(pins), .gpio_out(gout[0]), .gpio_oe(goe[0]), .irq(girq[0]));
  apb_gpio_slave #(.WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(rdat[1]), .PREADY(rdy[1]),
    .PSLVERR(serr[1]), .gpio_in(pins), .gpio_out(gout[1]), .gpio_oe(goe[1]), .irq(girq[1]));
  apb_gpio_slave #(.WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(rdat[2]), .PREADY(rdy[2]),
    .PSLVERR(serr[2]), .gpio_in(pins), .gpio_out(gout[2]), .gpio_oe(goe[2]), .irq(girq[2]));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Reference: register-map rules applied directly to the architectural state.
  function automatic void model(input bit wr, input logic [2:0] idx, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] er, output bit ee);
    logic [31:0] m;
    bit mapped;
    m = lanes(s);
    er = '0;
    ee = 1'b0;
    mapped = (idx <= 3'd2) || (HAS_IRQ && idx <= 3'd4);
    if (!mapped || (wr && idx == 3'd2)) ee = 1'b1;
    else if (!wr) begin
      case (idx)
        3'd0: er = m_dout;
        3'd1: er = m_dir;
        3'd2: er = m_pins;
        3'd3: er = m_ien;
        default: er = m_ist;
      endcase
    end else begin
      case (idx)
        3'd0: m_dout = (m_dout & ~m) | (d & m);
        3'd1: m_dir  = (m_dir & ~m) | (d & m);
        3'd3: m_ien  = (m_ien & ~m) | (d & m);
        default: m_ist = m_ist & ~(d & m);
      endcase
    end
  endfunction

  task automatic bus(input int k, input bit wr, input logic [2:0] idx, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output bit err,
                     output int n, output bit quiet);
    psel[k] = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = {1'b1, idx}; PWDATA = d; PSTRB = s;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    n = 0; quiet = 1'b1; rd = '0; err = 1'b0;
    while (1) begin
      n++;
      if (rdy[k]) begin
        rd = rdat[k];
        err = serr[k];
        break;
      end
      if (rdat[k] != 0 || serr[k]) quiet = 1'b0;
      if (n >= 40) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel[k] = 1'b0; PENABLE = 1'b0;
    if (rdy[k] || rdat[k] != 0 || serr[k]) quiet = 1'b0;
  endtask

  task automatic x0(input bit wr, input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] rd, output bit err);
    logic [31:0] er;
    bit ee, q;
    int n;
    model(wr, idx, d, s, er, ee);
    bus(0, wr, idx, d, s, rd, err, n, q);
    chk("ws1_latency", 32'(n), 32'd2);
    chk("idle_outputs_zero", 32'(q), 32'd1);
    chk("pslverr", 32'(err), 32'(ee));
    chk("prdata", rd, er);
    chk("gpio_out", gout[0], m_dout);
    chk("gpio_oe", goe[0], m_dir);
  endtask

  task automatic set_pins(input logic [31:0] v);
    if (HAS_IRQ) m_ist = m_ist | (v & ~m_pins & m_ien);
    m_pins = v;
    pins = v;
    repeat (4) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  idx;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] rd, v;
    bit err, q;
    int n;
    bit wr;
    logic [2:0] idx;
    logic [3:0] s;

    tbl[0]  = '{1'b1, 3'd0, 32'h11223344, 4'hF, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 3'd0, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 3'd0, 32'h0, 4'h0, 32'h11BB33DD, 1'b0};
    tbl[3]  = '{1'b0, 3'd1, 32'h0, 4'h0, 32'h0, 1'b0};
    tbl[4]  = '{1'b1, 3'd1, 32'h00FF00F0, 4'hF, 32'h0, 1'b0};
    tbl[5]  = '{1'b0, 3'd1, 32'h0, 4'h0, 32'h00FF00F0, 1'b0};
    tbl[6]  = '{1'b0, 3'd6, 32'h0, 4'h0, 32'h0, 1'b1};
    tbl[7]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
    tbl[8]  = '{1'b0, 3'd2, 32'h0, 4'h0, 32'h0, 1'b0};
    tbl[9]  = '{1'b1, 3'd0, 32'h12345678, 4'h0, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 3'd0, 32'h0, 4'h0, 32'h11BB33DD, 1'b0};
    tbl[11] = '{1'b0, 3'd3, 32'h0, 4'h0, 32'h0, !HAS_IRQ};
    tbl[12] = '{1'b1, 3'd7, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
    tbl[13] = '{1'b0, 3'd5, 32'h0, 4'h0, 32'h0, 1'b1};

    rst_n = 1'b0; psel = '0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
    PWDATA = '0; PSTRB = '0; pins = '0;
    m_dout = '0; m_dir = '0; m_ien = '0; m_ist = '0; m_pins = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pready", 32'(rdy), 32'd0);
    chk("reset_pslverr", 32'(serr), 32'd0);
    chk("reset_prdata", rdat[0], 32'd0);
    chk("reset_gpio_out", gout[0], 32'd0);
    chk("reset_gpio_oe", goe[0], 32'd0);
    chk("reset_irq", 32'(girq), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      x0(tbl[i].wr, tbl[i].idx, tbl[i].d, tbl[i].s, rd, err);
      chk($sformatf("vec%0d_prdata", i), rd, tbl[i].er);
      chk($sformatf("vec%0d_pslverr", i), 32'(err), 32'(tbl[i].ee));
      if (i == 1) chk("merged_gpio_out", gout[0], 32'h11BB33DD);
    end

    set_pins(32'hA5A50F0F);
    x0(1'b0, 3'd2, 32'h0, 4'h0, rd, err);
    chk("data_in_sync", rd, 32'hA5A50F0F);

    bus(1, 1'b0, 3'd1, 32'h0, 4'h0, rd, err, n, q);
    chk("ws3_latency", 32'(n), 32'd4);
    chk("ws3_quiet", 32'(q), 32'd1);
    bus(2, 1'b0, 3'd1, 32'h0, 4'h0, rd, err, n, q);
    chk("ws0_latency", 32'(n), 32'd1);
    bus(2, 1'b1, 3'd0, 32'hCAFEF00D, 4'hF, rd, err, n, q);
    chk("ws0_write_latency", 32'(n), 32'd1);
    chk("ws0_gpio_out", gout[2], 32'hCAFEF00D);
    bus(2, 1'b0, 3'd0, 32'h0, 4'h0, rd, err, n, q);
    chk("ws0_readback", rd, 32'hCAFEF00D);
    chk("ws0_quiet", 32'(q), 32'd1);
    bus(2, 1'b0, 3'd6, 32'h0, 4'h0, rd, err, n, q);
    chk("ws0_unmapped_err", 32'(err), 32'd1);
    chk("ws0_unmapped_data", rd, 32'd0);

    // Abort: PSEL drops while the write is still waiting.
    psel[0] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h8; PWDATA = 32'hDEADBEEF; PSTRB = 4'hF;
    @(posedge clk); #1;
    psel[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("abort_ws1_pready", 32'(rdy[0]), 32'd0);
    end
    x0(1'b0, 3'd0, 32'h0, 4'h0, rd, err);
    chk("abort_ws1_unchanged", rd, 32'h11BB33DD);

    psel[1] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h8; PWDATA = 32'hDEADBEEF; PSTRB = 4'hF;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    psel[1] = 1'b0; PENABLE = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("abort_ws3_pready", 32'(rdy[1]), 32'd0);
    end
    chk("abort_ws3_gpio_out", gout[1], 32'd0);
    bus(1, 1'b0, 3'd0, 32'h0, 4'h0, rd, err, n, q);
    chk("abort_ws3_readback", rd, 32'd0);
    chk("abort_ws3_next_latency", 32'(n), 32'd4);

`ifdef APB_GPIO_IRQ_EN
    x0(1'b1, 3'd3, 32'h1, 4'hF, rd, err);
    set_pins(m_pins & ~32'h3);
    set_pins(m_pins | 32'h1);
    x0(1'b0, 3'd4, 32'h0, 4'h0, rd, err);
    chk("irq_status_set", rd, 32'h1);
    chk("irq_asserted", 32'(girq[0]), 32'd1);
    x0(1'b1, 3'd4, 32'h1, 4'hF, rd, err);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_cleared", 32'(girq[0]), 32'd0);
    set_pins(m_pins | 32'h2);
    x0(1'b0, 3'd4, 32'h0, 4'h0, rd, err);
    chk("irq_disabled_bit", rd, 32'h0);
    chk("irq_disabled_line", 32'(girq[0]), 32'd0);
`else
    x0(1'b0, 3'd4, 32'h0, 4'h0, rd, err);
    chk("noirq_idx4_err", 32'(err), 32'd1);
    for (int c = 0; c < 6; c++) begin
      pins = $urandom;
      @(posedge clk); #1;
      chk("noirq_line", 32'(girq[0]), 32'd0);
    end
    set_pins(pins);
`endif

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(9) < 3) begin
        if ($urandom_range(1) == 0) v = m_pins ^ 32'($urandom);
        else v = m_pins ^ (32'h1 << $urandom_range(31));
        set_pins(v);
      end else begin
        wr  = 1'($urandom_range(1));
        idx = 3'($urandom_range(7));
        s   = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom);
        v   = $urandom;
        x0(wr, idx, v, s, rd, err);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rand_irq", 32'(girq[0]), 32'(|(m_ist & m_ien)));
    end

    // Reset in the middle of a write to DIR.
    psel[0] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h9; PWDATA = 32'h5555AAAA; PSTRB = 4'hF;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midreset_pready", 32'(rdy[0]), 32'd0);
    chk("midreset_prdata", rdat[0], 32'd0);
    chk("midreset_pslverr", 32'(serr[0]), 32'd0);
    chk("midreset_gpio_out", gout[0], 32'd0);
    chk("midreset_gpio_oe", goe[0], 32'd0);
    chk("midreset_irq", 32'(girq[0]), 32'd0);
    @(posedge clk); #1;
    psel[0] = 1'b0; PENABLE = 1'b0;
    rst_n = 1'b1;
    m_dout = '0; m_dir = '0; m_ien = '0; m_ist = '0;
    repeat (4) @(posedge clk);
    #1;
    x0(1'b1, 3'd1, 32'h5555AAAA, 4'hF, rd, err);
    x0(1'b0, 3'd1, 32'h0, 4'h0, rd, err);
    chk("post_reset_dir", rd, 32'h5555AAAA);
    x0(1'b0, 3'd2, 32'h0, 4'h0, rd, err);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
